// File: rtl/fp_addsub_seq_if.sv
// fp_addsub_seq_if: start/done handshake bundle between the core and the FP add/sub unit.
// The master side drives the operands; the slave side returns status and result.
interface fp_addsub_seq_if #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
);

    localparam int W = 1 + EXP_W + MAN_W;

    logic         start;
    logic         sub;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         ovf;

    modport master (
        output start, sub, op_a, op_b,
        input  busy, done, result, ovf
    );

    modport slave (
        input  start, sub, op_a, op_b,
        output busy, done, result, ovf
    );

endinterface

// File: rtl/fp_addsub_seq.sv
// fp_addsub_seq: multi-cycle floating-point add/subtract, one FSM state per cycle.
// Define FPADD_RNE_EN for round-to-nearest-even; otherwise results truncate toward zero.
module fp_addsub_seq #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic           clk,
    input  logic           reset,
    fp_addsub_seq_if.slave bus
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int SW    = MAN_W + 4;
    localparam int SHMAX = MAN_W + 3;

    localparam logic [EXP_W:0] E_ONE = (EXP_W+1)'(1);
    localparam logic [EXP_W:0] E_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALIGN,
        S_ADD,
        S_NORM,
        S_ROUND,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             sign_q, sign_d;
    logic             sgn_b_q, sgn_b_d;
    logic [EXP_W:0]   exp_q, exp_d;
    logic [EXP_W-1:0] exp_b_q, exp_b_d;
    logic [SW:0]      acc_q, acc_d;
    logic [SW-1:0]    opb_q, opb_d;
    logic [W-1:0]     result_q, result_d;
    logic             ovf_q, ovf_d;

    logic                   sa, sb;
    logic [EXP_W-1:0]       ea, eb;
    logic [MAN_W-1:0]       ma, mb;
    logic                   hid_a, hid_b;
    logic                   a_ge_b;

    assign sa    = bus.op_a[W-1];
    assign sb    = bus.op_b[W-1] ^ bus.sub;
    assign ea    = bus.op_a[W-2 -: EXP_W];
    assign eb    = bus.op_b[W-2 -: EXP_W];
    assign hid_a = |ea;
    assign hid_b = |eb;
    assign ma    = hid_a ? bus.op_a[MAN_W-1:0] : '0;
    assign mb    = hid_b ? bus.op_b[MAN_W-1:0] : '0;
    assign a_ge_b = {ea, ma} >= {eb, mb};

    // Alignment keeps everything shifted out as a single sticky bit.
    logic [31:0]   shamt;
    logic [SW-1:0] lost;
    logic [SW-1:0] opb_sh;

    assign shamt  = 32'(exp_q[EXP_W-1:0]) - 32'(exp_b_q);
    assign lost   = opb_q & ~({SW{1'b1}} << shamt);
    assign opb_sh = (shamt >= 32'(SHMAX))
                  ? {{(SW-1){1'b0}}, |opb_q}
                  : ((opb_q >> shamt) | {{(SW-1){1'b0}}, |lost});

    logic [SW:0] opb_ext;
    logic [SW:0] sum;

    assign opb_ext = {1'b0, opb_q};
    assign sum     = (sign_q == sgn_b_q) ? acc_q + opb_ext
                                         : acc_q - opb_ext;

    logic [MAN_W:0]   mant;
    logic             rnd_up;
    logic [MAN_W+1:0] mant_r;
    logic [MAN_W-1:0] man_fld;
    logic [EXP_W:0]   exp_r;

    assign mant = acc_q[SW-1:3];
`ifdef FPADD_RNE_EN
    assign rnd_up = acc_q[2] & (acc_q[1] | acc_q[0] | mant[0]);
`else
    assign rnd_up = 1'b0;
`endif
    assign mant_r  = {1'b0, mant} + (MAN_W+2)'(rnd_up);
    assign man_fld = mant_r[MAN_W+1] ? mant_r[MAN_W:1]
                                     : mant_r[MAN_W-1:0];
    assign exp_r   = exp_q + (EXP_W+1)'(mant_r[MAN_W+1]);

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        sgn_b_d  = sgn_b_q;
        exp_d    = exp_q;
        exp_b_d  = exp_b_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_ALIGN;
                    ovf_d   = 1'b0;
                    if (a_ge_b) begin
                        sign_d  = sa;
                        sgn_b_d = sb;
                        exp_d   = {1'b0, ea};
                        exp_b_d = eb;
                        acc_d   = {1'b0, hid_a, ma, 3'b000};
                        opb_d   = {hid_b, mb, 3'b000};
                    end else begin
                        sign_d  = sb;
                        sgn_b_d = sa;
                        exp_d   = {1'b0, eb};
                        exp_b_d = ea;
                        acc_d   = {1'b0, hid_b, mb, 3'b000};
                        opb_d   = {hid_a, ma, 3'b000};
                    end
                end
            end
            S_ALIGN: begin
                opb_d   = opb_sh;
                state_d = S_ADD;
            end
            S_ADD: begin
                acc_d   = sum;
                state_d = S_NORM;
            end
            S_NORM: begin
                state_d = S_ROUND;
                if (acc_q == '0) begin
                    sign_d = 1'b0;
                    exp_d  = '0;
                end else if (acc_q[SW]) begin
                    acc_d = {1'b0, acc_q[SW:2], acc_q[1] | acc_q[0]};
                    exp_d = exp_q + E_ONE;
                end else if (!acc_q[SW-1]) begin
                    // exp_q == 0 downstream marks a flushed/zero result
                    if (exp_q <= E_ONE) begin
                        acc_d  = '0;
                        exp_d  = '0;
                        sign_d = 1'b0;
                    end else begin
                        acc_d = {acc_q[SW-1:0], 1'b0};
                        exp_d = exp_q - E_ONE;
                        if (!acc_q[SW-2]) begin
                            state_d = S_NORM;
                        end
                    end
                end
            end
            S_ROUND: begin
                state_d = S_DONE;
                if (exp_q == '0) begin
                    result_d = '0;
                end else if (exp_r > E_MAX) begin
                    result_d = {sign_q, {(W-1){1'b1}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_q, exp_r[EXP_W-1:0], man_fld};
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sign_q   <= 1'b0;
            sgn_b_q  <= 1'b0;
            exp_q    <= '0;
            exp_b_q  <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            sgn_b_q  <= sgn_b_d;
            exp_q    <= exp_d;
            exp_b_q  <= exp_b_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// tb_fp_addsub_seq: directed and random checks of fp_addsub_seq against an
// exact-integer model of the sum, rounding, saturation and done timing.
`timescale 1ns/1ps
module tb_fp_addsub_seq;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [15:0] last_res;
    logic        last_ovf;
    int          ncyc;
    exp_t        m;
    logic [15:0] ra, rb;
    int          sel;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Exact value arithmetic on integers scaled to the smaller exponent,
    // then normalise/round the exact magnitude. lat = 4 + NORM cycles.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic sub);
        exp_t   r;
        int     ea, eb, emin, emax, p, e, k;
        longint va, vb, s, mg, q;
        logic   sa, sbb, sgn;
`ifdef FPADD_RNE_EN
        longint rem, half;
`endif
        r.res = 16'h0000;
        r.ovf = 1'b0;
        r.lat = 5;
        ea  = int'(a[14:10]);
        eb  = int'(b[14:10]);
        sa  = a[15];
        sbb = b[15] ^ sub;
        va  = (ea == 0) ? 0 : longint'(1024 + int'(a[9:0]));
        vb  = (eb == 0) ? 0 : longint'(1024 + int'(b[9:0]));
        if (va == 0 && vb == 0) return r;
        if (va == 0) begin
            emin = eb; emax = eb;
        end else if (vb == 0) begin
            emin = ea; emax = ea;
        end else begin
            emin = (ea < eb) ? ea : eb;
            emax = (ea > eb) ? ea : eb;
        end
        if (va != 0) va = va << (ea - emin);
        if (vb != 0) vb = vb << (eb - emin);
        s = (sa ? -va : va) + (sbb ? -vb : vb);
        if (s == 0) return r;
        sgn = (s < 0);
        mg  = sgn ? -s : s;
        p = 0;
        while ((mg >> (p + 1)) != 0) p++;
        e = emin + p - 10;
        if (e <= 0) begin
            r.lat = 4 + emax;
            return r;
        end
        k = emax - e;
        if (k < 1) k = 1;
        r.lat = 4 + k;
        if (p > 10) begin
            q = mg >> (p - 10);
`ifdef FPADD_RNE_EN
            rem  = mg - (q << (p - 10));
            half = longint'(1) << (p - 11);
            if (rem > half || (rem == half && q[0])) q++;
`endif
        end else begin
            q = mg << (10 - p);
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e > 31) begin
            r.res = {sgn, 15'h7FFF};
            r.ovf = 1'b1;
        end else begin
            r.res = {sgn, 5'(e), 10'(q - 1024)};
        end
        return r;
    endfunction

    // Per-cycle compare: done exactly at lat-1 negedges after the start edge.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            ncyc     = 0;
            last_res = 16'h0000;
            last_ovf = 1'b0;
        end else if (sb_q.size() != 0) begin
            chk("busy", 32'(bus.busy), 32'(ncyc < sb_q[0].lat - 1));
            chk("done", 32'(bus.done), 32'(ncyc == sb_q[0].lat - 1));
            if (bus.done) begin
                chk("result", 32'(bus.result), 32'(sb_q[0].res));
                chk("ovf", 32'(bus.ovf), 32'(sb_q[0].ovf));
                last_res = sb_q[0].res;
                last_ovf = sb_q[0].ovf;
                void'(sb_q.pop_front());
                ncyc = 0;
            end else if (ncyc > sb_q[0].lat + 4) begin
                chk("done_timeout", 32'(bus.done), 32'(1));
                void'(sb_q.pop_front());
                ncyc = 0;
            end else begin
                ncyc++;
            end
        end else begin
            chk("idle_busy", 32'(bus.busy), 32'(0));
            chk("idle_done", 32'(bus.done), 32'(0));
            chk("held_result", 32'(bus.result), 32'(last_res));
            chk("held_ovf", 32'(bus.ovf), 32'(last_ovf));
        end
    end

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (sb_q.size() != 0 && c < budget) begin
            @(posedge clk);
            #2;
            c++;
        end
        if (sb_q.size() != 0) chk("wait_bound", 32'(sb_q.size()), 32'(0));
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic s);
        exp_t e;
        e = model(a, b, s);
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.sub   = s;
        @(posedge clk);
        sb_q.push_back(e);
        #2;
        bus.start = 1'b0;
        bus.op_a  = 16'($urandom);
        bus.op_b  = 16'($urandom);
        bus.sub   = 1'($urandom);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic s);
        issue(a, b, s);
        wait_idle(40);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.op_a  = 16'h0000;
        bus.op_b  = 16'h0000;
        reset     = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        chk("reset_result", 32'(bus.result), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);

        m = model(16'h1A04, 16'h1A04, 1'b0);
        chk("t1_model_lat", 32'(m.lat), 32'd5);
        run_op(16'h1A04, 16'h1A04, 1'b0);
        chk("t1_result", 32'(bus.result), 32'h1E04);
        chk("t1_ovf", 32'(bus.ovf), 32'h0);

        run_op(16'h4204, 16'h4204, 1'b1);
        chk("t2_sub_result", 32'(bus.result), 32'h0000);
        run_op(16'h4204, 16'h4204, 1'b0);
        chk("t2_add_result", 32'(bus.result), 32'h4604);

        m = model(16'h3C01, 16'h3C00, 1'b1);
        chk("t3_model_lat", 32'(m.lat), 32'd14);
        run_op(16'h3C01, 16'h3C00, 1'b1);
        chk("t3_result", 32'(bus.result), 32'h1400);

        run_op(16'h3C00, 16'h1200, 1'b0);
`ifdef FPADD_RNE_EN
        chk("t4_result", 32'(bus.result), 32'h3C01);
`else
        chk("t4_result", 32'(bus.result), 32'h3C00);
`endif

        run_op(16'h7E0F, 16'h7E04, 1'b0);
        chk("t5_result", 32'(bus.result), 32'h7FFF);
        chk("t5_ovf", 32'(bus.ovf), 32'h1);
        run_op(16'h3C00, 16'h0000, 1'b0);
        chk("t5_next_result", 32'(bus.result), 32'h3C00);
        chk("t5_next_ovf", 32'(bus.ovf), 32'h0);

        // start held high through busy and DONE must not queue a second op
        issue(16'h3C00, 16'h4000, 1'b0);
        bus.start = 1'b1;
        bus.op_a  = 16'h1234;
        bus.op_b  = 16'h5678;
        wait_idle(40);
        bus.start = 1'b0;
        chk("t6_busy_start_result", 32'(bus.result), 32'h4200);
        repeat (6) @(posedge clk);
        #2;
        chk("t6_result_held", 32'(bus.result), 32'h4200);

        // reset sampled at the second edge of an operation aborts it
        issue(16'h4500, 16'h3C00, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        chk("t6_reset_result", 32'(bus.result), 32'h0);
        chk("t6_reset_busy", 32'(bus.busy), 32'h0);
        repeat (12) @(posedge clk);
        #2;

        for (int i = 0; i < 400; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            sel = $urandom_range(0, 5);
            if (sel == 0) begin
                rb[14:10] = ra[14:10];
            end else if (sel == 1) begin
                rb[14:10] = ra[14:10] - 5'($urandom_range(0, 3));
            end else if (sel == 2) begin
                ra[14:10] = 5'($urandom_range(29, 31));
                rb[14:10] = 5'($urandom_range(27, 31));
            end else if (sel == 3) begin
                ra[14:10] = 5'($urandom_range(1, 3));
                rb[14:10] = ra[14:10];
            end else if (sel == 4) begin
                if ($urandom_range(0, 1) == 1) ra[14:10] = 5'd0;
                else rb[14:10] = 5'd0;
            end
            run_op(ra, rb, 1'($urandom));
        end

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
